// File: rtl/ad_bus_responder_pkg.sv
// Shared definitions for the AD/ALE/RD/WR bus responder: word width,
// default window base, FSM state encoding and protocol-violation codes.
package ad_bus_responder_pkg;

   localparam int          BUS_W        = 16;
   localparam logic [15:0] DEFAULT_BASE = 16'hF0F0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_NSEL = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      VIOL_NONE        = 2'd0,
      VIOL_RD_WR       = 2'd1,
      VIOL_ALE_STROBE  = 2'd2,
      VIOL_IDLE_STROBE = 2'd3
   } viol_t;

endpackage

// File: rtl/ad_bus_responder_if.sv
// Bus strobes plus host-side port and status of the responder.
// The multiplexed AD lines stay a plain inout on the top module so the
// tri-state driver is resolved on an ordinary net.
interface ad_bus_responder_if #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
);
   logic              ALE;
   logic              RD;
   logic              WR;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [15:0]       host_wdata;
   logic [15:0]       host_rdata;
   logic [CNT_W-1:0]  rd_count;
   logic [CNT_W-1:0]  wr_count;
   logic              proto_err;
   logic              selected;

   modport master (
      output ALE, RD, WR, host_we, host_addr, host_wdata,
      input  host_rdata, rd_count, wr_count, proto_err, selected
   );

   modport slave (
      input  ALE, RD, WR, host_we, host_addr, host_wdata,
      output host_rdata, rd_count, wr_count, proto_err, selected
   );
endinterface

// File: rtl/ad_word_mem.sv
// 2**ADDR_W x 16 word memory: combinational bus read port, registered
// read-before-write host read port, bus and host write ports where the
// bus write wins on a same-index collision. Contents are never reset.
module ad_word_mem
   import ad_bus_responder_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] bus_raddr,
   output logic [BUS_W-1:0]  bus_rdata,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_waddr,
   input  logic [BUS_W-1:0]  bus_wdata,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [BUS_W-1:0]  host_wdata,
   output logic [BUS_W-1:0]  host_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [BUS_W-1:0] mem [DEPTH];
   logic             host_blocked;

   assign bus_rdata    = mem[bus_raddr];
   assign host_blocked = bus_we && (bus_waddr == host_addr);

   // Write ports; the host write is suppressed when the bus hits the same word
   always_ff @(posedge clk) begin
      if (bus_we) begin
         mem[bus_waddr] <= bus_wdata;
      end
      if (host_we && !host_blocked) begin
         mem[host_addr] <= host_wdata;
      end
   end

   // Registered host read, sampling the pre-write contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         host_rdata <= '0;
      end else begin
         host_rdata <= mem[host_addr];
      end
   end

endmodule

// File: rtl/ad_bus_responder.sv
// Responder end of the multiplexed AD/ALE/RD/WR bus. Latches and decodes
// the address phase against a base window, returns prefetched read data
// with zero wait states, captures bus writes into a local word memory and
// tracks transaction counts and a sticky protocol-error flag.
module ad_bus_responder
   import ad_bus_responder_pkg::*;
#(
   parameter int          ADDR_W    = 4,
   parameter logic [15:0] BASE_ADDR = DEFAULT_BASE,
   parameter int          CNT_W     = 8
) (
   input  logic             Clk1,
   input  logic             Rst,
   inout  wire [BUS_W-1:0]  AD,
   ad_bus_responder_if.slave bus
);

   state_t            state;
   state_t            state_nxt;
   viol_t             viol;
   logic [ADDR_W-1:0] addr_q;
   logic [BUS_W-1:0]  rd_data_q;
   logic [BUS_W-1:0]  mem_rdata;
   logic              rd_prev;
   logic              wr_prev;
   logic [CNT_W-1:0]  rd_count;
   logic [CNT_W-1:0]  wr_count;
   logic              proto_err;
   logic              hit;
   logic              drive;
   logic              bus_we;
   logic              rd_rise;
   logic              wr_rise;

   ad_word_mem #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk        (Clk1),
      .rst        (Rst),
      .bus_raddr  (AD[ADDR_W-1:0]),
      .bus_rdata  (mem_rdata),
      .bus_we     (bus_we),
      .bus_waddr  (addr_q),
      .bus_wdata  (AD),
      .host_we    (bus.host_we),
      .host_addr  (bus.host_addr),
      .host_wdata (bus.host_wdata),
      .host_rdata (bus.host_rdata)
   );

   // Tri-state driver: only a clean read strobe in SEL turns the bus around
   assign AD = drive ? rd_data_q : {BUS_W{1'bz}};

   assign bus.rd_count  = rd_count;
   assign bus.wr_count  = wr_count;
   assign bus.proto_err = proto_err;
   assign bus.selected  = (state == ST_SEL);

   // Window decode, next state, violation classification and strobe qualification
   always_comb begin
      hit       = (AD[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
      state_nxt = state;
      viol      = VIOL_NONE;
      drive     = 1'b0;
      bus_we    = 1'b0;
      rd_rise   = 1'b0;
      wr_rise   = 1'b0;

      if (bus.ALE) begin
         state_nxt = hit ? ST_SEL : ST_NSEL;
      end

      if (bus.RD && bus.WR) begin
         viol = VIOL_RD_WR;
      end else if (bus.ALE && (bus.RD || bus.WR)) begin
         viol = VIOL_ALE_STROBE;
      end else if ((state == ST_IDLE) && (bus.RD || bus.WR)) begin
         viol = VIOL_IDLE_STROBE;
      end

      if ((state == ST_SEL) && !bus.ALE) begin
         drive  = bus.RD && !bus.WR;
         bus_we = bus.WR && !bus.RD;
      end

      rd_rise = drive && !rd_prev;
      wr_rise = bus_we && !wr_prev;
   end

   // State register
   always_ff @(posedge Clk1 or posedge Rst) begin
      if (Rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Address latch and read prefetch; a bus write keeps the prefetched word coherent
   always_ff @(posedge Clk1 or posedge Rst) begin
      if (Rst) begin
         addr_q    <= '0;
         rd_data_q <= '0;
      end else begin
         if (bus.ALE) begin
            addr_q <= AD[ADDR_W-1:0];
            if (hit) begin
               rd_data_q <= mem_rdata;
            end
         end else if (bus_we) begin
            rd_data_q <= AD;
         end
      end
   end

   // Strobe history, transaction counters and sticky protocol error
   always_ff @(posedge Clk1 or posedge Rst) begin
      if (Rst) begin
         rd_prev   <= 1'b0;
         wr_prev   <= 1'b0;
         rd_count  <= '0;
         wr_count  <= '0;
         proto_err <= 1'b0;
      end else begin
         rd_prev <= bus.RD;
         wr_prev <= bus.WR;
         if (rd_rise) begin
            rd_count <= rd_count + 1'b1;
         end
         if (wr_rise) begin
            wr_count <= wr_count + 1'b1;
         end
         if (viol != VIOL_NONE) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ad_bus_responder.sv
// Directed bench for ad_bus_responder: a vector table for the main bus and
// host traffic, then hand-written sequences for held reads, RD+WR collision,
// asynchronous reset during a read and strobe-in-IDLE / ALE-with-RD errors.
// A pulldown on AD makes a released bus read back as 16'h0000.
module tb_ad_bus_responder;
   import ad_bus_responder_pkg::*;

   logic        clk;
   logic        rst;
   logic        m_en;
   logic [15:0] m_data;
   wire  [15:0] ad_w;

   int checks = 0;
   int errors = 0;

   ad_bus_responder_if #(.ADDR_W(4), .CNT_W(8)) bus ();

   assign ad_w = m_en ? m_data : 16'hzzzz;
   pulldown (ad_w);

   ad_bus_responder #(
      .ADDR_W    (4),
      .BASE_ADDR (16'hF0F0),
      .CNT_W     (8)
   ) dut (
      .Clk1 (clk),
      .Rst  (rst),
      .AD   (ad_w),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ale;
      logic        rd;
      logic        wr;
      logic        m_en;
      logic [15:0] m_data;
      logic        hwe;
      logic [3:0]  haddr;
      logic [15:0] hwdata;
      logic [15:0] exp_ad;
      logic        exp_sel;
      logic [7:0]  exp_rdc;
      logic [7:0]  exp_wrc;
      logic        exp_err;
      logic        chk_h;
      logic [15:0] exp_h;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ale, input logic rd, input logic wr,
                        input logic en, input logic [15:0] data);
      bus.ALE = ale;
      bus.RD  = rd;
      bus.WR  = wr;
      m_en    = en;
      m_data  = data;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            ale rd wr men mdata     hwe ha  hwdata    exp_ad    sel rdc wrc err chk exp_h
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,4'd6,16'h0006, 16'h0000, 1'b0,8'd0,8'd0,1'b0, 1'b0,16'h0000};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b0,8'd0,8'd0,1'b0, 1'b1,16'h0006};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,16'hF0F6, 1'b0,4'd6,16'h0000, 16'hF0F6, 1'b1,8'd0,8'd0,1'b0, 1'b1,16'h0006};
      vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0006, 1'b1,8'd1,8'd0,1'b0, 1'b1,16'h0006};
      vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b1,8'd1,8'd0,1'b0, 1'b1,16'h0006};
      vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,16'hABCD, 1'b0,4'd6,16'h0000, 16'hABCD, 1'b1,8'd1,8'd1,1'b0, 1'b1,16'h0006};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b1,8'd1,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'hABCD, 1'b1,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b1,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,16'h1236, 1'b0,4'd6,16'h0000, 16'h1236, 1'b0,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b0,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b0,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b1,16'hF0E6, 1'b0,4'd6,16'h0000, 16'hF0E6, 1'b0,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[13] = '{1'b1,1'b0,1'b0,1'b1,16'hF0FF, 1'b0,4'd6,16'h0000, 16'hF0FF, 1'b1,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[14] = '{1'b1,1'b0,1'b0,1'b1,16'hF0F6, 1'b0,4'd6,16'h0000, 16'hF0F6, 1'b1,8'd2,8'd1,1'b0, 1'b1,16'hABCD};
      vecs[15] = '{1'b0,1'b0,1'b1,1'b1,16'h1111, 1'b1,4'd6,16'h2222, 16'h1111, 1'b1,8'd2,8'd2,1'b0, 1'b1,16'hABCD};
      vecs[16] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,4'd6,16'h0000, 16'h0000, 1'b1,8'd2,8'd2,1'b0, 1'b1,16'h1111};

      rst            = 1'b1;
      bus.host_we    = 1'b0;
      bus.host_addr  = 4'd6;
      bus.host_wdata = 16'h0000;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      next_cycle();
      next_cycle();

      chk("reset_selected", 32'(bus.selected), 32'd0);
      chk("reset_rd_count", 32'(bus.rd_count), 32'd0);
      chk("reset_wr_count", 32'(bus.wr_count), 32'd0);
      chk("reset_proto_err", 32'(bus.proto_err), 32'd0);
      chk("reset_host_rdata", 32'(bus.host_rdata), 32'd0);
      chk("reset_ad_released", 32'(ad_w), 32'h0000);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].ale, vecs[i].rd, vecs[i].wr, vecs[i].m_en, vecs[i].m_data);
         bus.host_we    = vecs[i].hwe;
         bus.host_addr  = vecs[i].haddr;
         bus.host_wdata = vecs[i].hwdata;
         @(negedge clk);
         chk($sformatf("v%0d_ad", i), 32'(ad_w), 32'(vecs[i].exp_ad));
         next_cycle();
         chk($sformatf("v%0d_selected", i), 32'(bus.selected), 32'(vecs[i].exp_sel));
         chk($sformatf("v%0d_rd_count", i), 32'(bus.rd_count), 32'(vecs[i].exp_rdc));
         chk($sformatf("v%0d_wr_count", i), 32'(bus.wr_count), 32'(vecs[i].exp_wrc));
         chk($sformatf("v%0d_proto_err", i), 32'(bus.proto_err), 32'(vecs[i].exp_err));
         if (vecs[i].chk_h) begin
            chk($sformatf("v%0d_host_rdata", i), 32'(bus.host_rdata), 32'(vecs[i].exp_h));
         end
      end
      bus.host_we = 1'b0;

      // RD held for three cycles: same word driven, one completed read
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
         @(negedge clk);
         chk($sformatf("hold%0d_ad", c), 32'(ad_w), 32'h1111);
         next_cycle();
      end
      chk("hold_rd_count", 32'(bus.rd_count), 32'd3);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      next_cycle();

      // RD and WR together in SEL: flagged, bus released, no write
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      chk("rdwr_ad_released", 32'(ad_w), 32'h0000);
      next_cycle();
      chk("rdwr_proto_err", 32'(bus.proto_err), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      next_cycle();
      chk("rdwr_mem_kept", 32'(bus.host_rdata), 32'h1111);
      chk("rdwr_wr_count", 32'(bus.wr_count), 32'd2);
      next_cycle();
      chk("err_sticky", 32'(bus.proto_err), 32'd1);

      // Asynchronous reset while a read is being driven
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      chk("pre_reset_ad", 32'(ad_w), 32'h1111);
      rst = 1'b1;
      #1;
      chk("async_reset_ad", 32'(ad_w), 32'h0000);
      chk("async_reset_selected", 32'(bus.selected), 32'd0);
      chk("async_reset_rd_count", 32'(bus.rd_count), 32'd0);
      chk("async_reset_wr_count", 32'(bus.wr_count), 32'd0);
      chk("async_reset_proto_err", 32'(bus.proto_err), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      next_cycle();
      rst = 1'b0;
      next_cycle();
      chk("reset_mem_intact", 32'(bus.host_rdata), 32'h1111);

      // RD in IDLE is a violation and is never answered
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      chk("idle_rd_ad", 32'(ad_w), 32'h0000);
      next_cycle();
      chk("idle_rd_proto_err", 32'(bus.proto_err), 32'd1);
      chk("idle_rd_count", 32'(bus.rd_count), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      // ALE with RD: address still latched, violation flagged
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hF0F6);
      next_cycle();
      chk("ale_rd_selected", 32'(bus.selected), 32'd1);
      chk("ale_rd_proto_err", 32'(bus.proto_err), 32'd1);
      chk("ale_rd_count", 32'(bus.rd_count), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
